apb_completer_mem: RTL

APB completer backed by a small word-addressed register memory. It sits directly downstream of `controller_wrapper` and answers the transfers that the controller drives onto the APB bus: setup and access phases, programmable wait states, byte strobes and PSLVERR. It gives the controller a deterministic peer for bring-up and waveform checks.

---
 rtl/apb_completer_mem.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/apb_completer_mem.sv
// APB completer with a small word-addressed register memory, programmable wait
// states, byte strobes and PSLVERR for misaligned or out-of-range accesses.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module apb_completer_mem #(
  parameter int ADDR_WIDTH  = `ADDR_WIDTH,
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                    i_PCLK,
  input  logic                    i_PRESETn,
  input  logic                    i_PSEL,
  input  logic                    i_PENABLE,
  input  logic                    i_PWRITE,
  input  logic [ADDR_WIDTH-1:0]   i_PADDR,
  input  logic [DATA_WIDTH-1:0]   i_PWDATA,
  input  logic [DATA_WIDTH/8-1:0] i_PSTRB,
  output logic [DATA_WIDTH-1:0]   o_PRDATA,
  output logic                    o_PREADY,
  output logic                    o_PSLVERR
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_write;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_strb;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_prdata;

  logic [ADDR_WIDTH-1:0] w_word;
  logic [IDX_W-1:0]      w_new_idx;
  logic                  w_misal;
  logic                  w_oor;
  logic                  w_new_err;
  logic                  w_setup;
  logic                  w_mem_we;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_word    = i_PADDR >> LSB;
  assign w_new_idx = w_word[IDX_W-1:0];
  assign w_oor     = (32'(w_word) >= 32'(DEPTH));
  assign w_new_err = w_misal | w_oor;
  assign w_setup   = i_PSEL & ~i_PENABLE;

  generate
    if (LSB == 0) begin : g_no_align
      assign w_misal = 1'b0;
    end else begin : g_align
      assign w_misal = |i_PADDR[LSB-1:0];
    end
  endgenerate

  // Strobed lanes take new data, the rest keep the stored bytes.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign w_merged[gi*8 +: 8] = r_strb[gi] ? r_wdata[gi*8 +: 8] : r_mem[r_idx][gi*8 +: 8];
    end
  endgenerate

  // The write commits on the edge leaving READY, and only if PSEL is still held.
  assign w_mem_we = (r_state == S_READY) & i_PSEL & r_write & ~r_err;

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_mem_we) begin
      r_mem[r_idx] <= w_merged;
    end
  end

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_idx   <= w_new_idx;
            r_write <= i_PWRITE;
            r_err   <= w_new_err;
            r_wdata <= i_PWDATA;
            r_strb  <= i_PSTRB;
            r_cnt   <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              r_state   <= S_READY;
              r_pready  <= 1'b1;
              r_pslverr <= w_new_err;
              r_prdata  <= (w_new_err | i_PWRITE) ? '0 : r_mem[w_new_idx];
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!i_PSEL) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == 4'd1) begin
            r_state   <= S_READY;
            r_cnt     <= '0;
            r_pready  <= 1'b1;
            r_pslverr <= r_err;
            r_prdata  <= (r_err | r_write) ? '0 : r_mem[r_idx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_READY: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_PRDATA  = r_prdata;
  assign o_PREADY  = r_pready;
  assign o_PSLVERR = r_pslverr;

endmodule
